// File: rtl/stereo_channel_select.sv
// -----------------------------------------------------------------------------
// stereo_channel_select
//
// Routes one of NUM_CH packed input channels to a registered output stream.
// Channel switches are requested with sel_req/sel. A switch is taken up on
// the first in_valid after busy rises, so the sample that arrives together
// with a request still comes from the old channel.
//
// Optional feature, enabled by defining the macro STEREO_CHSEL_SOFT_MUTE_EN:
//   soft mute -- on a switch, MUTE_SAMPLES zero samples are emitted before
//   the new channel is routed, which hides the step between channels.
// With the macro undefined the MUTE state is unreachable and the switch
// completes on the first in_valid, which already carries the new channel.
// -----------------------------------------------------------------------------
module stereo_channel_select #(
  parameter int DATA_W       = 18,
  parameter int NUM_CH       = 2,
  parameter int MUTE_SAMPLES = 4,
  localparam int SEL_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_req,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     busy,
  output logic                     sel_err
);

`ifdef STEREO_CHSEL_SOFT_MUTE_EN
  localparam bit C_SOFT_MUTE = 1'b1;
`else
  localparam bit C_SOFT_MUTE = 1'b0;
`endif

  // Number of channel slots addressable by a SEL_W-bit index.
  localparam int C_SLOTS = 2 ** SEL_W;

  // NUM_CH widened by one bit so that out-of-range selects compare cleanly.
  localparam logic [SEL_W:0] C_NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

  // Mute length as an 8-bit count (MUTE_SAMPLES is limited to 1..255).
  localparam logic [7:0] C_MUTE = 8'(MUTE_SAMPLES);

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_MUTE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_active;
  logic                r_busy;
  logic [SEL_W-1:0]    r_pend;
  logic [7:0]          r_mute_cnt;
  logic                r_sel_err;

  // Next-state values
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic                w_out_valid_nxt;
  logic [SEL_W-1:0]    w_active_nxt;
  logic                w_busy_nxt;
  logic [SEL_W-1:0]    w_pend_nxt;
  logic [7:0]          w_mute_cnt_nxt;
  logic                w_sel_err_nxt;
  logic                w_complete;

  // Request decode
  logic                w_sel_oor;
  logic                w_req_ignore;
  logic                w_req_load;

  // Unpacked channel view; slots beyond NUM_CH read as zero so that any
  // SEL_W-bit index is safe.
  logic [DATA_W-1:0]   w_ch [C_SLOTS];
  logic [DATA_W-1:0]   w_active_sample;
  logic [DATA_W-1:0]   w_pend_sample;

  genvar g;
  generate
    for (g = 0; g < C_SLOTS; g++) begin : g_slot
      if (g < NUM_CH) begin : g_used
        assign w_ch[g] = in_data[g*DATA_W +: DATA_W];
      end else begin : g_pad
        assign w_ch[g] = '0;
      end
    end
  endgenerate

  assign w_active_sample = w_ch[r_active];
  assign w_pend_sample   = w_ch[r_pend];

  // Classify the incoming switch request: out of range, redundant, or to be loaded.
  always_comb begin
    w_sel_oor    = ({1'b0, sel} >= C_NUM_CH_EXT);
    w_req_ignore = (r_state == ST_PASS) && !r_busy && (sel == r_active);
    if (sel_req && !w_sel_oor && !w_req_ignore) begin
      w_req_load = 1'b1;
    end else begin
      w_req_load = 1'b0;
    end
  end

  // Datapath and FSM next-state: routing, zero insertion and switch completion.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = in_valid;
    w_mute_cnt_nxt  = r_mute_cnt;
    w_complete      = 1'b0;

    case (r_state)
      ST_PASS: begin
        if (in_valid) begin
          if (r_busy) begin
            if (C_SOFT_MUTE) begin
              // First zero of the gap is emitted on the entering sample.
              w_out_data_nxt = '0;
              if (C_MUTE == 8'd1) begin
                w_complete = 1'b1;
              end else begin
                w_state_nxt    = ST_MUTE;
                w_mute_cnt_nxt = 8'd1;
              end
            end else begin
              // Without soft mute the new channel is routed immediately.
              w_out_data_nxt = w_pend_sample;
              w_complete     = 1'b1;
            end
          end else begin
            w_out_data_nxt = w_active_sample;
          end
        end else begin
          w_out_data_nxt = r_out_data;
        end
      end

      ST_MUTE: begin
        if (in_valid) begin
          w_out_data_nxt = '0;
          if (r_mute_cnt >= (C_MUTE - 8'd1)) begin
            // This edge registers the last zero of the gap.
            w_complete     = 1'b1;
            w_state_nxt    = ST_PASS;
            w_mute_cnt_nxt = 8'd0;
          end else begin
            w_mute_cnt_nxt = r_mute_cnt + 8'd1;
          end
        end else begin
          w_out_data_nxt = r_out_data;
        end
      end

      default: begin
        w_state_nxt    = ST_PASS;
        w_mute_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Switch bookkeeping: completion commits the pending channel, then a new
  // accepted request (re)arms busy with the latest pending value.
  always_comb begin
    w_active_nxt  = r_active;
    w_busy_nxt    = r_busy;
    w_pend_nxt    = r_pend;
    w_sel_err_nxt = sel_req && w_sel_oor;

    if (w_complete) begin
      w_active_nxt = r_pend;
      w_busy_nxt   = 1'b0;
    end else begin
      w_active_nxt = r_active;
    end

    if (w_req_load) begin
      w_pend_nxt = sel;
      w_busy_nxt = 1'b1;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PASS;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_active    <= '0;
      r_busy      <= 1'b0;
      r_pend      <= '0;
      r_mute_cnt  <= 8'd0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_active    <= w_active_nxt;
      r_busy      <= w_busy_nxt;
      r_pend      <= w_pend_nxt;
      r_mute_cnt  <= w_mute_cnt_nxt;
      r_sel_err   <= w_sel_err_nxt;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign active_sel = r_active;
  assign busy       = r_busy;
  assign sel_err    = r_sel_err;

endmodule
